// File: rtl/tmu2_linefill_pkg.sv
// tmu2_linefill_pkg
//   Shared constants for the TMU2 texture-cache line-fill engine: FML burst
//   geometry, cache line geometry and the fill FSM state encodings.
package tmu2_linefill_pkg;

  // One cache line is fetched as a single FML burst of four 64-bit beats.
  localparam int FML_BEATS  = 4;
  localparam int FML_DW     = 64;
  localparam int LINE_BYTES = 32;
  localparam int LINE_SHIFT = 5;

  // Fill FSM state encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/tmu2_linefill.sv
// tmu2_linefill
//   Texture-cache line-fill engine. Accepts a miss request (memory line
//   address + cache line index), issues one 4-beat FML burst read, writes the
//   returned beats into the cache data RAM write port and pulses done once
//   the whole line is in the RAM.
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   req_valid/req_ready       fill request handshake (ready only when idle)
//   req_adr                   memory line address (32-byte units)
//   req_idx                   destination cache line index
//   fml_adr/fml_stb/fml_ack   FML burst request (byte address, low 5 bits 0)
//   fml_di                    FML read data, beats in A+1..A+4
//   wa/we/wd                  cache data RAM write port
//   done/done_idx             one-cycle completion pulse and its line index
//   busy                      high whenever the engine is not idle
//
// All outputs are registered. Writes land on the RAM port in A+2..A+5 and
// done follows in A+6, so a reader presenting the line address on or after
// done always sees the new data.
module tmu2_linefill
  import tmu2_linefill_pkg::*;
#(
  parameter int cache_depth = 13,
  parameter int fml_depth   = 26
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [fml_depth-6:0]     req_adr,
  input  logic [cache_depth-6:0]   req_idx,

  output logic [fml_depth-1:0]     fml_adr,
  output logic                     fml_stb,
  input  logic                     fml_ack,
  input  logic [FML_DW-1:0]        fml_di,

  output logic [cache_depth-4:0]   wa,
  output logic                     we,
  output logic [FML_DW-1:0]        wd,

  output logic                     done,
  output logic [cache_depth-6:0]   done_idx,
  output logic                     busy
);

  logic [1:0]               state_reg;
  logic [cache_depth-6:0]   idx_reg;
  // Beat counter; it only ever counts within its 2-bit field, so the low
  // word-address bits of a line never carry into the line index.
  logic [1:0]               cnt_reg;

  localparam logic [1:0] LAST_BEAT = 2'(FML_BEATS - 1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      req_ready <= 1'b1;
      fml_adr   <= '0;
      fml_stb   <= 1'b0;
      wa        <= '0;
      we        <= 1'b0;
      wd        <= '0;
      done      <= 1'b0;
      done_idx  <= '0;
      busy      <= 1'b0;
    end else begin
      // Strobe-like outputs default low; each state raises what it needs.
      we   <= 1'b0;
      done <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            idx_reg   <= req_idx;
            fml_adr   <= {req_adr, {LINE_SHIFT{1'b0}}};
            fml_stb   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_reg <= ST_REQ;
          end
        end

        ST_REQ: begin
          // fml_stb/fml_adr simply hold until the controller acknowledges.
          if (fml_ack) begin
            fml_stb   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_DATA;
          end
        end

        ST_DATA: begin
          // Every cycle here carries one beat; forward it straight to the
          // RAM port through the output registers.
          we      <= 1'b1;
          wd      <= fml_di;
          wa      <= {idx_reg, cnt_reg};
          cnt_reg <= cnt_reg + 2'd1;
          if (cnt_reg == LAST_BEAT) begin
            state_reg <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          // The last write is on the RAM port this cycle; done goes out one
          // edge later so it never precedes the data.
          done      <= 1'b1;
          done_idx  <= idx_reg;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmu2_linefill.sv
// tb_tmu2_linefill
//   Directed testbench for tmu2_linefill with a small read-through RAM model
//   attached to the write port. Inputs change on the falling edge, outputs
//   are checked on the falling edge.
module tb_tmu2_linefill;

  localparam int CD  = 15;
  localparam int FD  = 26;
  localparam int IW  = CD - 5;
  localparam int AW  = FD - 5;
  localparam int WW  = CD - 3;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_adr;
  logic [IW-1:0]  req_idx;
  logic [FD-1:0]  fml_adr;
  logic           fml_stb;
  logic           fml_ack;
  logic [63:0]    fml_di;
  logic [WW-1:0]  wa;
  logic           we;
  logic [63:0]    wd;
  logic           done;
  logic [IW-1:0]  done_idx;
  logic           busy;

  always #5 sys_clk = ~sys_clk;

  tmu2_linefill #(
    .cache_depth (CD),
    .fml_depth   (FD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_adr   (req_adr),
    .req_idx   (req_idx),
    .fml_adr   (fml_adr),
    .fml_stb   (fml_stb),
    .fml_ack   (fml_ack),
    .fml_di    (fml_di),
    .wa        (wa),
    .we        (we),
    .wd        (wd),
    .done      (done),
    .done_idx  (done_idx),
    .busy      (busy)
  );

  // Cache data RAM model: registered read address, read-through data.
  logic [63:0]   mem [0:(1<<WW)-1];
  logic [WW-1:0] ra;
  logic [WW-1:0] ra_reg;
  logic [63:0]   rd;

  always @(posedge sys_clk) begin
    if (we) mem[wa] <= wd;
    ra_reg <= ra;
  end
  assign rd = mem[ra_reg];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one complete fill starting at a falling edge where the engine is
  // idle, ending at the falling edge of cycle A+6 (done visible).
  //   waits     : cycles of fml_ack low before the ack cycle
  //   hold_next : keep req_valid high afterwards with nadr/nidx
  //   poke      : pulse req_valid with nadr/nidx during DATA (must be ignored)
  task automatic fill(input string tag, input logic [AW-1:0] adr, input logic [IW-1:0] idx,
                      input int waits, input logic [63:0] base, input bit hold_next,
                      input logic [AW-1:0] nadr, input logic [IW-1:0] nidx, input bit poke);
    logic [FD-1:0] exp_adr;
    logic [1:0]    b;
    bit            exp_we;
    exp_adr = {adr, 5'b0};
    check({tag, ".ready_start"}, req_ready, 1);
    req_valid = 1'b1;
    req_adr   = adr;
    req_idx   = idx;
    fml_ack   = 1'b0;
    @(negedge sys_clk);
    check({tag, ".stb"}, fml_stb, 1);
    check({tag, ".fml_adr"}, fml_adr, exp_adr);
    check({tag, ".busy"}, busy, 1);
    check({tag, ".ready_busy"}, req_ready, 0);
    req_valid = hold_next;
    if (hold_next) begin
      req_adr = nadr;
      req_idx = nidx;
    end
    for (int w = 0; w <= waits; w++) begin
      if (w > 0) begin
        @(negedge sys_clk);
        check({tag, ".stb_hold"}, fml_stb, 1);
        check({tag, ".adr_hold"}, fml_adr, exp_adr);
      end
      fml_ack = (w == waits);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge sys_clk);
      fml_ack = 1'b0;
      exp_we = (k >= 2) && (k <= 5);
      check({tag, ".stb_low"}, fml_stb, 0);
      check({tag, ".we"}, we, exp_we);
      if (exp_we) begin
        b = 2'(k - 2);
        check({tag, ".wa"}, wa, {idx, b});
        check({tag, ".wd"}, wd, base + 64'(k - 2));
      end
      check({tag, ".done"}, done, (k == 6));
      check({tag, ".ready"}, req_ready, (k == 6));
      check({tag, ".busy_k"}, busy, (k != 6));
      if (k == 6) check({tag, ".done_idx"}, done_idx, idx);
      fml_di = (k <= 4) ? base + 64'(k - 1) : 64'hDEAD_BEEF_DEAD_BEEF;
      if (poke && k == 2) begin
        req_valid = 1'b1;
        req_adr   = nadr;
        req_idx   = nidx;
      end
      if (poke && k == 3) req_valid = 1'b0;
    end
    $display("fill %s adr=0x%0h idx=0x%0h waits=%0d done_idx=0x%0h", tag, adr, idx, waits, done_idx);
  endtask

  initial begin
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    req_adr   = '0;
    req_idx   = '0;
    fml_ack   = 1'b0;
    fml_di    = '0;
    ra        = '0;

    repeat (2) @(negedge sys_clk);
    check("rst.ready", req_ready, 1);
    check("rst.stb", fml_stb, 0);
    check("rst.we", we, 0);
    check("rst.done", done, 0);
    check("rst.busy", busy, 0);
    check("rst.fml_adr", fml_adr, 0);
    check("rst.wa", wa, 0);
    check("rst.wd", wd, 0);
    check("rst.done_idx", done_idx, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("idle.ready", req_ready, 1);

    // Single fill with three wait cycles before the ack.
    fill("single", 21'h12345, 10'h007, 3, 64'hA0, 1'b0, '0, '0, 1'b0);
    check("single.fml_adr_const", fml_adr, 26'h024_68A0);
    @(negedge sys_clk);

    // Ack already high in the first REQ cycle.
    fill("ack0", 21'h00ABC, 10'h155, 0, 64'hB0, 1'b0, '0, '0, 1'b0);
    @(negedge sys_clk);

    // Back-to-back with req_valid held; second accept happens at done.
    fill("b2b0", 21'h1FFFF, 10'h3FF, 1, 64'hC0, 1'b1, 21'h00001, 10'h000, 1'b0);
    fill("b2b1", 21'h00001, 10'h000, 2, 64'hD0, 1'b0, '0, '0, 1'b0);
    @(negedge sys_clk);

    // Request pulsed while busy must be ignored; stray ack in idle too.
    fill("poke", 21'h0F0F0, 10'h021, 1, 64'hE0, 1'b0, 21'h0AAAA, 10'h099, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("poke.idle_stb", fml_stb, 0);
      check("poke.idle_busy", busy, 0);
      fml_ack = (i == 1);
    end
    fill("repost", 21'h0AAAA, 10'h099, 0, 64'hF0, 1'b0, '0, '0, 1'b0);
    @(negedge sys_clk);

    // Reset asserted in A+3 of a burst.
    req_valid = 1'b1;
    req_adr   = 21'h00777;
    req_idx   = 10'h0AB;
    @(negedge sys_clk);
    check("rstmid.stb", fml_stb, 1);
    req_valid = 1'b0;
    fml_ack   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge sys_clk);
      fml_ack = 1'b0;
      if (k == 3) check("rstmid.we_before", we, 1);
      if (k >= 4) begin
        check("rstmid.we", we, 0);
        check("rstmid.stb_low", fml_stb, 0);
        check("rstmid.done", done, 0);
        check("rstmid.ready", req_ready, 1);
        check("rstmid.busy", busy, 0);
      end
      sys_rst = (k == 3);
      fml_di  = (k <= 4) ? 64'h50 + 64'(k - 1) : 64'h0;
    end
    $display("reset mid-burst adr=0x777 idx=0xab");
    @(negedge sys_clk);

    // Read-after-fill through the RAM model.
    fill("raf", 21'h03030, 10'h012, 1, 64'h1234_5678_9ABC_DE00, 1'b0, '0, '0, 1'b0);
    ra = {10'h012, 2'd2};
    @(negedge sys_clk);
    check("raf.rd_beat2", rd, 64'h1234_5678_9ABC_DE02);
    ra = {10'h012, 2'd0};
    @(negedge sys_clk);
    check("raf.rd_beat0", rd, 64'h1234_5678_9ABC_DE00);
    ra = {10'h3FF, 2'd3};
    @(negedge sys_clk);
    check("raf.rd_b2b_last", rd, 64'hC3);
    $display("read-after-fill idx=0x12 rd=0x%0h", rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmu2_linefill.md
Name: tmu2_linefill

Overview:
- Texture-cache line-fill engine for TMU2.
- Accepts a miss request (memory line address plus cache line index) and issues one 4-beat FML burst read.
- Writes the returned 64-bit beats into the write port of the cache data RAM, a 1R/1W read-through dual-port RAM.
- Reports completion to the miss handler.
- Sits directly upstream of the cache data RAM write port.

Parameters:
- cache_depth, 13, log2 of cache capacity in bytes; RAM word address width is cache_depth-3.
- fml_depth, 26, log2 of FML address space in bytes.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- req_valid  in  1  fill request present
- req_ready  out  1  engine idle, request accepted when req_valid & req_ready
- req_adr  in  fml_depth-5  memory line address (32-byte aligned)
- req_idx  in  cache_depth-5  destination cache line index
- fml_adr  out  fml_depth  burst byte address
- fml_stb  out  1  burst request strobe
- fml_ack  in  1  burst acknowledge
- fml_di  in  64  FML read data
- wa  out  cache_depth-3  RAM write address
- we  out  1  RAM write enable
- wd  out  64  RAM write data
- done  out  1  one-cycle pulse, line fully written
- done_idx  out  cache_depth-5  line index for the completed fill
- busy  out  1  high whenever not IDLE

Behaviour:
- Reset values: req_ready=1, fml_stb=0, we=0, done=0, busy=0.
- Reset values for address/data outputs: fml_adr=0, wa=0, wd=0, done_idx=0.
- All outputs are registered.
- FML read protocol: 4 beats on fml_di in cycles A+1..A+4, where A is the cycle with fml_stb & fml_ack.
- FSM states: IDLE, REQ, DATA, FINISH.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_adr/req_idx.
  - fml_adr <= {req_adr, 5'b0}; fml_stb <= 1; go to REQ.
- REQ:
  - Hold fml_stb and fml_adr stable until fml_ack.
  - In cycle A, fml_stb <= 0, beat counter <= 0, go to DATA.
  - fml_stb must never be high outside REQ; no second request before done.
- DATA:
  - Each cycle, capture fml_di.
  - Registered write: we=1, wd=beat, wa={idx, cnt[1:0]} in cycles A+2..A+5.
  - Beat order is 0,1,2,3; the counter wraps only within the 2-bit field.
  - After the 4th beat is captured (cycle A+4), go to FINISH.
- FINISH (cycle A+5):
  - Last write is on the RAM port.
  - Register done=1, done_idx=idx, visible in cycle A+6; done_idx holds until the next done.
  - Return to IDLE: req_ready=1 in A+6.
  - A reader may present ra for this line in cycle A+6 or later and get new data, because writes precede done by ≥1 edge.
- Latency: request accept to fml_stb is 1 cycle; fml_ack to done is 6 cycles.
- Back-to-back operation:
  - req_valid held in A+6 is accepted that cycle; fml_stb is high again in A+7.
  - Minimum spacing between bursts is 7 cycles plus ack wait.
- Simultaneous events:
  - req_valid while busy is ignored (req_ready=0); the requester must hold it.
  - fml_ack outside REQ is ignored.
- Reset mid-operation: return to IDLE immediately and drop fml_stb/we/done. Any in-flight beats are discarded, because the system resets the FML controller together with the engine.
- Width rules:
  - wa width is cache_depth-3 = (cache_depth-5)+2.
  - fml_adr low 5 bits are always 0.

Decomposition:
- Shared tmu2 package constants:
  - FML_BEATS=4
  - FML_DW=64
  - LINE_BYTES=32, LINE_SHIFT=5
  - State encodings IDLE/REQ/DATA/FINISH
- No sub-module: datapath is a 2-bit counter plus registers.
- Instantiated beside the cache data RAM (width=64, depth=cache_depth-3) in the cache top.

Test Plan:
- Single fill: req_adr=0x12345, req_idx=0x07, fml_ack after 3 wait cycles, beats 0xA0..0xA3.
  - Required: fml_adr=0x0246_8A0.
  - Required: writes wa=0x1C,0x1D,0x1E,0x1F with wd=0xA0..0xA3 in A+2..A+5.
  - Required: done=1, done_idx=7 at A+6.
- Ack in same cycle as strobe rise: fml_ack=1 in the first REQ cycle.
  - Required: exactly one burst, 4 writes, done 6 cycles later, fml_stb low from A+1.
- Back-to-back: req_valid held continuously with idx 0x3FF then 0x000.
  - Required: second accept in cycle of first done.
  - Required: second write addresses wrap to wa=0x000..0x003; no overlap of we between lines.
- Request while busy: pulse a different req_valid during DATA.
  - Required: req_ready=0, request ignored, no FML activity until it is re-presented in IDLE.
- Reset mid-burst: assert sys_rst in cycle A+3.
  - Required: next cycle we=0, fml_stb=0, done=0, req_ready=1; remaining beats produce no writes.
- Read-after-fill with the cache data RAM attached: on done, present ra={idx,2}.
  - Required: rd equals beat 2 the cycle after ra is registered.
